// File: rtl/mux_invert_pipe_if.sv
// Valid/ready bus between a producer/consumer pair and the select/invert pipe.
// The pipe itself connects through the slave modport.
interface mux_invert_pipe_if #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4,
   parameter int SEL_W = $clog2(N_CH)
);
   logic                    in_valid;
   logic                    in_ready;
   logic [N_CH*WIDTH-1:0]   in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_inv;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    sel_err;

   modport master (
      output in_valid, in_data, in_sel, in_inv, out_ready,
      input  in_ready, out_valid, out_data, out_sel, sel_err
   );

   modport slave (
      input  in_valid, in_data, in_sel, in_inv, out_ready,
      output in_ready, out_valid, out_data, out_sel, sel_err
   );
endinterface

// File: rtl/mux_invert_pipe.sv
// Two-stage valid/ready pipe: stage 1 selects one of N_CH channels and captures the invert
// request, stage 2 applies the invert and holds the result for the consumer.
module mux_invert_pipe #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4,
   parameter int SEL_W = $clog2(N_CH)
) (
   input logic              clk,
   input logic              rst_n,
   mux_invert_pipe_if.slave bus
);

   logic              s1Valid_q, s1Valid_d;
   logic [WIDTH-1:0]  s1Data_q,  s1Data_d;
   logic              s1Inv_q,   s1Inv_d;
   logic [SEL_W-1:0]  s1Sel_q,   s1Sel_d;
   logic              outValid_q, outValid_d;
   logic [WIDTH-1:0]  outData_q,  outData_d;
   logic [SEL_W-1:0]  outSel_q,   outSel_d;
   logic              selErr_q,   selErr_d;

   logic [WIDTH-1:0]  selData;
   logic              selOk;
   logic [WIDTH-1:0]  invData;
   logic              s2Free;
   logic              s1Adv;
   logic              inReady;
   logic              inFire;

   // Selects never matching a real channel leave selData at zero and selOk low.
   always_comb begin
      selData = '0;
      selOk   = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (bus.in_sel == SEL_W'(k)) begin
            selData = bus.in_data[k*WIDTH +: WIDTH];
            selOk   = 1'b1;
         end
      end
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_invMux
      assign invData[b] = s1Inv_q ? ~s1Data_q[b] : s1Data_q[b];
   end

   assign s2Free  = !outValid_q || bus.out_ready;
   assign s1Adv   = s1Valid_q && s2Free;
   assign inReady = !s1Valid_q || s2Free;
   assign inFire  = bus.in_valid && inReady;

   always_comb begin
      s1Valid_d  = s1Valid_q;
      s1Data_d   = s1Data_q;
      s1Inv_d    = s1Inv_q;
      s1Sel_d    = s1Sel_q;
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outSel_d   = outSel_q;
      selErr_d   = selErr_q;

      if (s1Adv) begin
         s1Valid_d = 1'b0;
      end
      if (inFire) begin
         s1Valid_d = 1'b1;
         s1Data_d  = selData;
         s1Inv_d   = bus.in_inv;
         s1Sel_d   = bus.in_sel;
         if (!selOk) begin
            selErr_d = 1'b1;
         end
      end

      // A drain and a reload on the same edge leave stage 2 full with the newer result.
      if (outValid_q && bus.out_ready) begin
         outValid_d = 1'b0;
      end
      if (s1Adv) begin
         outValid_d = 1'b1;
         outData_d  = invData;
         outSel_d   = s1Sel_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q  <= 1'b0;
         s1Data_q   <= '0;
         s1Inv_q    <= 1'b0;
         s1Sel_q    <= '0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outSel_q   <= '0;
         selErr_q   <= 1'b0;
      end else begin
         s1Valid_q  <= s1Valid_d;
         s1Data_q   <= s1Data_d;
         s1Inv_q    <= s1Inv_d;
         s1Sel_q    <= s1Sel_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outSel_q   <= outSel_d;
         selErr_q   <= selErr_d;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid_q;
   assign bus.out_data  = outData_q;
   assign bus.out_sel   = outSel_q;
   assign bus.sel_err   = selErr_q;

endmodule

// File: tb/tb_mux_invert_pipe.sv
// Bench for mux_invert_pipe: a 4-channel instance for the main traffic and a 3-channel
// instance for out-of-range selects, both checked against an in-order queue model.
module tb_mux_invert_pipe;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] s;
   } expT;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   expT  expQ[$];

   mux_invert_pipe_if #(.WIDTH(8), .N_CH(4)) busA ();
   mux_invert_pipe_if #(.WIDTH(8), .N_CH(3)) busB ();

   mux_invert_pipe #(.WIDTH(8), .N_CH(4)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busA)
   );

   mux_invert_pipe #(.WIDTH(8), .N_CH(3)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected result: the chosen byte (zero when no such channel exists), complemented on request.
   function automatic logic [7:0] refModel(input logic [31:0] word, input int sel, input bit inv,
                                           input int nch);
      int chan;
      chan = (sel < nch) ? int'((word >> (sel * 8)) & 32'hFF) : 0;
      if (inv) chan = 255 - chan;
      return chan[7:0];
   endfunction

   // One clock cycle on the chosen bus: drive, sample before the rising edge, advance to the next falling edge.
   task automatic step(input bit useB, input bit v, input logic [31:0] word, input int sel,
                       input bit inv, input bit ordy, output bit acc, output bit del,
                       output logic [7:0] od, output logic [1:0] os, output logic irdy,
                       output logic ov);
      if (!useB) begin
         busA.in_valid  = v;
         busA.in_data   = word;
         busA.in_sel    = sel[1:0];
         busA.in_inv    = inv;
         busA.out_ready = ordy;
         busB.in_valid  = 1'b0;
         busB.out_ready = 1'b1;
      end else begin
         busB.in_valid  = v;
         busB.in_data   = word[23:0];
         busB.in_sel    = sel[1:0];
         busB.in_inv    = inv;
         busB.out_ready = ordy;
         busA.in_valid  = 1'b0;
         busA.out_ready = 1'b1;
      end
      #1;
      if (!useB) begin
         irdy = busA.in_ready; ov = busA.out_valid; od = busA.out_data; os = busA.out_sel;
      end else begin
         irdy = busB.in_ready; ov = busB.out_valid; od = busB.out_data; os = busB.out_sel;
      end
      acc = v && (irdy === 1'b1);
      del = (ov === 1'b1) && ordy;
      if (acc) expQ.push_back({refModel(word, sel, inv, useB ? 3 : 4), sel[1:0]});
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sends one request with the consumer always ready and reports when and what came out.
   task automatic sendAndWait(input bit useB, input logic [31:0] word, input int sel, input bit inv,
                              output int lat, output logic [7:0] rd, output logic [1:0] rs);
      bit acc, del;
      logic [7:0] od;
      logic [1:0] os;
      logic irdy, ov;
      lat = -1;
      rd  = 'x;
      rs  = 'x;
      step(useB, 1'b1, word, sel, inv, 1'b1, acc, del, od, os, irdy, ov);
      for (int i = 1; i <= 8; i++) begin
         step(useB, 1'b0, word, sel, inv, 1'b1, acc, del, od, os, irdy, ov);
         if (del) begin
            lat = i; rd = od; rs = os;
            break;
         end
      end
   endtask

   task automatic test_reset();
      tests++;
      if (busA.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got=%b exp=0", busA.out_valid); end
      tests++;
      if (busA.out_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_out_data got=%h exp=00", busA.out_data); end
      tests++;
      if (busA.sel_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_sel_err got=%b exp=0", busA.sel_err); end
      tests++;
      if (busA.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got=%b exp=1", busA.in_ready); end
      tests++;
      if (busB.out_valid !== 1'b0 || busB.sel_err !== 1'b0) begin
         fails++; $display("[TB] FAIL reset_b got valid=%b err=%b exp 0 0", busB.out_valid, busB.sel_err);
      end
   endtask

   task automatic test_pass_invert();
      int lat;
      logic [7:0] rd;
      logic [1:0] rs;
      expQ.delete();
      sendAndWait(1'b0, 32'h44332211, 2, 1'b0, lat, rd, rs);
      tests++;
      if (rd !== 8'h33 || rs !== 2'd2) begin fails++; $display("[TB] FAIL pass_sel2 got=%h/%0d exp=33/2", rd, rs); end
      tests++;
      if (lat !== 2) begin fails++; $display("[TB] FAIL latency got=%0d exp=2", lat); end
      sendAndWait(1'b0, 32'h44332211, 0, 1'b1, lat, rd, rs);
      tests++;
      if (rd !== 8'hEE || rs !== 2'd0) begin fails++; $display("[TB] FAIL invert_sel0 got=%h/%0d exp=EE/0", rd, rs); end
      sendAndWait(1'b0, 32'h00000000, 1, 1'b1, lat, rd, rs);
      tests++;
      if (rd !== 8'hFF) begin fails++; $display("[TB] FAIL not_of_00 got=%h exp=FF", rd); end
      sendAndWait(1'b0, 32'h0000FF00, 1, 1'b1, lat, rd, rs);
      tests++;
      if (rd !== 8'h00) begin fails++; $display("[TB] FAIL not_of_FF got=%h exp=00", rd); end
      expQ.delete();
   endtask

   task automatic test_back_to_back();
      bit acc, del, allReady;
      logic [7:0] od;
      logic [1:0] os;
      logic irdy, ov;
      int sent, got, first, last;
      expT e;
      expQ.delete();
      sent = 0; got = 0; first = -1; last = -1; allReady = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
         step(1'b0, sent < 16, $urandom, sent % 4, sent % 2, 1'b1, acc, del, od, os, irdy, ov);
         if (sent < 16 && irdy !== 1'b1) allReady = 1'b0;
         if (acc) sent++;
         if (del) begin
            tests++;
            if (expQ.size() == 0) begin
               fails++; $display("[TB] FAIL stream_extra got=%h exp=none", od);
            end else begin
               e = expQ.pop_front();
               if (od !== e.d || os !== e.s) begin
                  fails++; $display("[TB] FAIL stream_data got=%h/%0d exp=%h/%0d", od, os, e.d, e.s);
               end
            end
            if (first < 0) first = cyc;
            last = cyc;
            got++;
         end
      end
      tests++;
      if (got != 16) begin fails++; $display("[TB] FAIL stream_count got=%0d exp=16", got); end
      tests++;
      if (!allReady) begin fails++; $display("[TB] FAIL stream_in_ready got=0 exp=1"); end
      tests++;
      if (last - first != 15) begin fails++; $display("[TB] FAIL stream_rate got=%0d exp=15", last - first); end
   endtask

   task automatic test_backpressure();
      bit acc, del;
      logic [7:0] od, held;
      logic [1:0] os;
      logic irdy, ov;
      logic [31:0] words [3];
      int idx, got;
      expT e;
      expQ.delete();
      for (int i = 0; i < 3; i++) words[i] = $urandom;
      idx = 0; got = 0; held = 'x;
      for (int s = 0; s < 5; s++) begin
         step(1'b0, idx < 3, words[idx % 3], (idx + 1) % 4, idx % 2, 1'b0, acc, del, od, os, irdy, ov);
         if (s == 2) begin
            held = od;
            tests++;
            if (irdy !== 1'b0) begin fails++; $display("[TB] FAIL bp_full_in_ready got=%b exp=0", irdy); end
         end
         if (s == 4) begin
            tests++;
            if (od !== held || ov !== 1'b1 || od !== expQ[0].d) begin
               fails++; $display("[TB] FAIL bp_stable got=%h exp=%h", od, expQ[0].d);
            end
         end
         if (acc) idx++;
      end
      tests++;
      if (idx != 2) begin fails++; $display("[TB] FAIL bp_accepted got=%0d exp=2", idx); end
      for (int s = 0; s < 12 && got < 3; s++) begin
         step(1'b0, idx < 3, words[idx % 3], (idx + 1) % 4, idx % 2, 1'b1, acc, del, od, os, irdy, ov);
         if (s == 0) begin
            tests++;
            if (irdy !== 1'b1) begin fails++; $display("[TB] FAIL bp_release_in_ready got=%b exp=1", irdy); end
         end
         if (acc) idx++;
         if (del) begin
            tests++;
            if (expQ.size() == 0) begin
               fails++; $display("[TB] FAIL bp_extra got=%h exp=none", od);
            end else begin
               e = expQ.pop_front();
               if (od !== e.d || os !== e.s) begin
                  fails++; $display("[TB] FAIL bp_data got=%h/%0d exp=%h/%0d", od, os, e.d, e.s);
               end
            end
            got++;
         end
      end
      tests++;
      if (got != 3 || expQ.size() != 0) begin
         fails++; $display("[TB] FAIL bp_count got=%0d left=%0d exp=3 left=0", got, expQ.size());
      end
   endtask

   task automatic test_out_of_range();
      int lat;
      logic [7:0] rd;
      logic [1:0] rs;
      expQ.delete();
      sendAndWait(1'b1, $urandom, 3, 1'b0, lat, rd, rs);
      tests++;
      if (rd !== 8'h00 || rs !== 2'd3) begin fails++; $display("[TB] FAIL oor_pass got=%h/%0d exp=00/3", rd, rs); end
      tests++;
      if (busB.sel_err !== 1'b1) begin fails++; $display("[TB] FAIL oor_sel_err got=%b exp=1", busB.sel_err); end
      sendAndWait(1'b1, $urandom, 3, 1'b1, lat, rd, rs);
      tests++;
      if (rd !== 8'hFF) begin fails++; $display("[TB] FAIL oor_invert got=%h exp=FF", rd); end
      sendAndWait(1'b1, 32'h00A5C300, 1, 1'b0, lat, rd, rs);
      tests++;
      if (rd !== 8'hC3) begin fails++; $display("[TB] FAIL b_valid_sel got=%h exp=C3", rd); end
      sendAndWait(1'b1, 32'h00A5C300, 2, 1'b1, lat, rd, rs);
      tests++;
      if (busB.sel_err !== 1'b1) begin fails++; $display("[TB] FAIL oor_sticky got=%b exp=1", busB.sel_err); end
      tests++;
      if (busA.sel_err !== 1'b0) begin fails++; $display("[TB] FAIL a_sel_err got=%b exp=0", busA.sel_err); end
      expQ.delete();
   endtask

   task automatic test_reset_mid();
      bit acc, del;
      logic [7:0] od;
      logic [1:0] os;
      logic irdy, ov;
      logic [31:0] word;
      int got;
      expT e;
      expQ.delete();
      for (int s = 0; s < 4; s++) step(1'b0, s < 2, $urandom, s, 1'b0, 1'b0, acc, del, od, os, irdy, ov);
      tests++;
      if (busA.out_valid !== 1'b1 || busB.sel_err !== 1'b1) begin
         fails++; $display("[TB] FAIL pre_reset got valid=%b err=%b exp 1 1", busA.out_valid, busB.sel_err);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (busA.out_valid !== 1'b0 || busB.sel_err !== 1'b0 || busA.in_ready !== 1'b1) begin
         fails++; $display("[TB] FAIL async_reset got valid=%b err=%b rdy=%b exp 0 0 1",
                           busA.out_valid, busB.sel_err, busA.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      expQ.delete();
      got = 0;
      word = $urandom;
      for (int s = 0; s < 7; s++) begin
         step(1'b0, s == 0, word, 3, 1'b1, 1'b1, acc, del, od, os, irdy, ov);
         if (del) begin
            got++;
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               tests++;
               if (od !== e.d || os !== e.s) begin
                  fails++; $display("[TB] FAIL post_reset_data got=%h exp=%h", od, e.d);
               end
            end
         end
      end
      tests++;
      if (got != 1) begin fails++; $display("[TB] FAIL post_reset_count got=%0d exp=1", got); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      busA.in_valid = 1'b0; busA.in_data = '0; busA.in_sel = '0; busA.in_inv = 1'b0; busA.out_ready = 1'b1;
      busB.in_valid = 1'b0; busB.in_data = '0; busB.in_sel = '0; busB.in_inv = 1'b0; busB.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_pass_invert();
      test_back_to_back();
      test_backpressure();
      test_out_of_range();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
